// File: rtl/cu_definitions_pkg.sv
// cu_definitions_pkg: control-unit encodings shared with the decoder
package cu_definitions_pkg;
   localparam logic [1:0] MEM_TO_REG_PIX = 2'b10;
endpackage

// File: rtl/stages_definition_pkg.sv
// stages_definition_pkg: state types for the pixel memory arbiter
package stages_definition_pkg;
   typedef enum logic {CP_IDLE, CP_RDRET} pix_cpu_phase_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_DISP} pix_rd_tag_t;
endpackage

// File: rtl/pix_arb_starve_ctr.sv
// pix_arb_starve_ctr: saturating count of cycles a CPU request lost to display
module pix_arb_starve_ctr #(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt,
   output logic         o_sat
);
   logic [W-1:0] r_cnt;
   assign o_cnt = r_cnt;
   assign o_sat = r_cnt == W'(MAX);
   // clear wins over increment; increment stops at MAX
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_inc && !o_sat) r_cnt <= r_cnt + W'(1);
   end
endmodule

// File: rtl/pix_mem_arbiter.sv
// pix_mem_arbiter: shares the pixel RAM between CPU MEM stage and display scan-out
module pix_mem_arbiter
   import stages_definition_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int CPU_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_stall,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   output logic [ADDR_W-1:0] pm_addr,
   output logic              pm_we,
   output logic [DATA_W-1:0] pm_wdata,
   input  logic [DATA_W-1:0] pm_rdata
);
   localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
   pix_cpu_phase_t    cpu_phase_q, w_phase_d;
   pix_rd_tag_t       rd_tag_q, w_tag_d;
   logic [WAIT_W-1:0] wait_q;
   logic              w_sat, w_cpu_req, w_elig, w_cpu_win, w_disp_win, w_cpu_wr_win;
   logic [DATA_W-1:0] r_cpu_rdata, r_disp_rdata;
   pix_arb_starve_ctr #(.MAX(CPU_MAX_WAIT), .W(WAIT_W)) u_starve (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_elig && w_cpu_req && w_disp_win),
      .i_clr (w_cpu_win || !w_cpu_req),
      .o_cnt (wait_q),
      .o_sat (w_sat)
   );
   // arbitration, next state and RAM/handshake outputs; a starved CPU pre-empts display
   always_comb begin
      w_cpu_req    = cpu_rd | cpu_wr;
      w_elig       = cpu_phase_q == CP_IDLE;
      w_cpu_win    = w_elig && w_cpu_req && (w_sat || !disp_req);
      w_disp_win   = disp_req && !w_cpu_win;
      w_cpu_wr_win = w_cpu_win && cpu_wr;
      w_phase_d    = (w_cpu_win && !cpu_wr) ? CP_RDRET : CP_IDLE;
      w_tag_d      = (w_cpu_win && !cpu_wr) ? TAG_CPU : w_disp_win ? TAG_DISP : TAG_NONE;
      pm_addr      = w_cpu_win ? cpu_addr : w_disp_win ? disp_addr : '0;
      pm_we        = w_cpu_wr_win;
      pm_wdata     = w_cpu_wr_win ? cpu_wdata : '0;
      disp_gnt     = w_disp_win;
      cpu_stall    = w_cpu_req && !w_cpu_wr_win && cpu_phase_q != CP_RDRET;
      cpu_rvalid   = rd_tag_q == TAG_CPU;
      disp_rvalid  = rd_tag_q == TAG_DISP;
      cpu_rdata    = cpu_rvalid ? pm_rdata : r_cpu_rdata;
      disp_rdata   = disp_rvalid ? pm_rdata : r_disp_rdata;
   end
   // state registers; reset drops any read issued in the reset cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_phase_q  <= CP_IDLE;
         rd_tag_q     <= TAG_NONE;
         r_cpu_rdata  <= '0;
         r_disp_rdata <= '0;
      end else begin
         cpu_phase_q  <= w_phase_d;
         rd_tag_q     <= w_tag_d;
         r_cpu_rdata  <= cpu_rdata;
         r_disp_rdata <= disp_rdata;
      end
   end
endmodule

// File: tb/tb_pix_mem_arbiter.sv
// tb_pix_mem_arbiter: directed checks of the pixel memory arbiter with a RAM model
module tb_pix_mem_arbiter;
   logic        clk = 0, rst = 1;
   logic        cpu_rd = 0, cpu_wr = 0, disp_req = 0;
   logic [15:0] cpu_addr = 0, disp_addr = 0, pm_addr;
   logic [7:0]  cpu_wdata = 0, cpu_rdata, disp_rdata, pm_wdata, pm_rdata = 0;
   logic        cpu_rvalid, cpu_stall, disp_gnt, disp_rvalid, pm_we;
   logic [7:0]  mem [0:65535];
   int          n_chk = 0, n_fail = 0;
   pix_mem_arbiter dut (
      .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .cpu_stall(cpu_stall), .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_gnt(disp_gnt), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .pm_addr(pm_addr), .pm_we(pm_we), .pm_wdata(pm_wdata), .pm_rdata(pm_rdata)
   );
   always #5 clk = ~clk;
   // synchronous single-port RAM, read latency 1
   always @(posedge clk) begin
      pm_rdata <= mem[pm_addr];
      if (pm_we) mem[pm_addr] <= pm_wdata;
   end
   function automatic logic [7:0] pix(input int a);
      return 8'(a * 3 + 1);
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pix(i);
      tick;
      tick;
      rst = 0;
      #1;
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_disp_rvalid", disp_rvalid, 0);
      chk("rst_disp_gnt", disp_gnt, 0);
      chk("rst_pm_we", pm_we, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      chk("rst_pm_addr", pm_addr, 0);
      tick;
      rst = 1; cpu_rd = 1; cpu_addr = 16'h0005;
      tick;
      rst = 0;
      #1;
      chk("rstrd_no_rvalid", cpu_rvalid, 0);
      chk("rstrd_idle_stall", cpu_stall, 1);
      tick;
      cpu_rd = 0;
      #1;
      chk("rstrd_rvalid", cpu_rvalid, 1);
      chk("rstrd_rdata", cpu_rdata, pix(5));
      tick;
      cpu_wr = 1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
      #1;
      chk("wr_pm_we", pm_we, 1);
      chk("wr_stall", cpu_stall, 0);
      chk("wr_pm_addr", pm_addr, 16'h0010);
      chk("wr_pm_wdata", pm_wdata, 8'hA5);
      tick;
      cpu_wr = 0;
      tick;
      cpu_rd = 1;
      #1;
      chk("rd_stall", cpu_stall, 1);
      chk("rd_pm_we", pm_we, 0);
      tick;
      cpu_rd = 0;
      #1;
      chk("rd_rvalid", cpu_rvalid, 1);
      chk("rd_rdata", cpu_rdata, 8'hA5);
      chk("rd_ret_stall", cpu_stall, 0);
      tick;
      chk("rd_hold_rvalid", cpu_rvalid, 0);
      chk("rd_hold_rdata", cpu_rdata, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         disp_req = 1; disp_addr = 16'(i);
         #1;
         chk("burst_gnt", disp_gnt, 1);
         chk("burst_pm_addr", pm_addr, i);
         if (i > 0) begin
            chk("burst_rvalid", disp_rvalid, 1);
            chk("burst_rdata", disp_rdata, pix(i - 1));
         end
         tick;
      end
      disp_req = 0;
      #1;
      chk("burst_last_rvalid", disp_rvalid, 1);
      chk("burst_last_rdata", disp_rdata, pix(7));
      chk("burst_end_gnt", disp_gnt, 0);
      tick;
      chk("burst_hold_rdata", disp_rdata, pix(7));
      cpu_rd = 1; cpu_addr = 16'h0010; disp_req = 1;
      for (int c = 1; c <= 5; c++) begin
         disp_addr = 16'h0020 + 16'(c);
         #1;
         chk("starve_stall", cpu_stall, 1);
         chk("starve_gnt", disp_gnt, c < 5);
         chk("starve_pm_addr", pm_addr, c < 5 ? 32'h20 + c : 32'h10);
         tick;
      end
      cpu_rd = 0; disp_addr = 16'h0026;
      #1;
      chk("starve_rvalid", cpu_rvalid, 1);
      chk("starve_rdata", cpu_rdata, 8'hA5);
      chk("starve_ret_stall", cpu_stall, 0);
      chk("starve_regain_gnt", disp_gnt, 1);
      chk("starve_no_disp_rvalid", disp_rvalid, 0);
      tick;
      disp_req = 0;
      #1;
      chk("starve_disp_rdata", disp_rdata, pix(16'h26));
      tick;
      cpu_rd = 1; cpu_wr = 1; cpu_addr = 16'h0030; cpu_wdata = 8'h5A;
      #1;
      chk("both_pm_we", pm_we, 1);
      chk("both_stall", cpu_stall, 0);
      tick;
      cpu_rd = 0; cpu_wr = 0;
      #1;
      chk("both_no_rvalid", cpu_rvalid, 0);
      tick;
      cpu_rd = 1; cpu_addr = 16'h0030;
      #1;
      chk("alt_stall", cpu_stall, 1);
      tick;
      cpu_rd = 0; disp_req = 1; disp_addr = 16'h0003;
      #1;
      chk("alt_cpu_rvalid", cpu_rvalid, 1);
      chk("alt_cpu_rdata", cpu_rdata, 8'h5A);
      chk("alt_disp_gnt", disp_gnt, 1);
      chk("alt_disp_rvalid0", disp_rvalid, 0);
      tick;
      disp_req = 0;
      #1;
      chk("alt_disp_rvalid", disp_rvalid, 1);
      chk("alt_disp_rdata", disp_rdata, pix(3));
      chk("alt_cpu_rvalid0", cpu_rvalid, 0);
      chk("alt_cpu_hold", cpu_rdata, 8'h5A);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
